// File: rtl/day_glyph_pkg.sv
// Shared types, day/glyph limits and the 3-glyph day abbreviation table
// for the day display scanner and its downstream decoder tests.
package day_glyph_pkg;

    typedef logic [2:0] day_t;
    typedef logic [4:0] glyph_t;

    typedef enum logic {
        SCAN_GAP,
        SCAN_SHOW
    } scan_state_t;

    localparam day_t   DAY_MAX     = 3'd6;
    localparam day_t   DAY_INVALID = 3'd7;
    localparam glyph_t GLYPH_MAX   = 5'd16;

    // Letter glyph indices understood by the decoder; 14..16 are spare.
    localparam glyph_t G_M = 5'd0;
    localparam glyph_t G_O = 5'd1;
    localparam glyph_t G_N = 5'd2;
    localparam glyph_t G_T = 5'd3;
    localparam glyph_t G_U = 5'd4;
    localparam glyph_t G_E = 5'd5;
    localparam glyph_t G_W = 5'd6;
    localparam glyph_t G_D = 5'd7;
    localparam glyph_t G_H = 5'd8;
    localparam glyph_t G_F = 5'd9;
    localparam glyph_t G_R = 5'd10;
    localparam glyph_t G_I = 5'd11;
    localparam glyph_t G_S = 5'd12;
    localparam glyph_t G_A = 5'd13;

    localparam glyph_t GLYPH_TABLE [7][3] = '{
        '{G_M, G_O, G_N},
        '{G_T, G_U, G_E},
        '{G_W, G_E, G_D},
        '{G_T, G_H, G_U},
        '{G_F, G_R, G_I},
        '{G_S, G_A, G_T},
        '{G_S, G_U, G_N}
    };

    function automatic glyph_t glyph_lookup(input day_t d, input logic [1:0] p);
        glyph_lookup = (d <= DAY_MAX && p <= 2'd2) ? GLYPH_TABLE[d][p] : '0;
    endfunction

endpackage

// File: rtl/day_glyph_scanner_scan_timer.sv
// Digit scan timer: GAP/SHOW state machine stepping a 0..2 digit position
// and producing the one-hot digit enable.
module scan_timer
    import day_glyph_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 1000,
    parameter int unsigned BLANK_GAP = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    output logic [2:0] o_digit_sel,
    output logic       o_advance,
    output logic [1:0] o_next_pos
);

    localparam int unsigned CNT_MAX = (SCAN_DIV > BLANK_GAP) ? SCAN_DIV : BLANK_GAP;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] SHOW_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((BLANK_GAP > 0) ? BLANK_GAP - 1 : 0);

    scan_state_t r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]    r_pos, w_pos_nxt, w_pos_inc;
    logic          w_advance;
    logic [2:0]    w_digit_sel;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= SCAN_GAP;
            r_cnt   <= '0;
            r_pos   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pos   <= w_pos_nxt;
        end
    end

    // With BLANK_GAP=0 the GAP state is only ever the single post-reset entry point.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_pos_nxt   = r_pos;
        w_advance   = 1'b0;
        w_digit_sel = '0;
        w_pos_inc   = (r_pos == 2'd2) ? 2'd0 : r_pos + 2'd1;
        case (r_state)
            SCAN_GAP: begin
                if (BLANK_GAP == 0 || r_cnt == GAP_LAST) begin
                    w_state_nxt = SCAN_SHOW;
                    w_cnt_nxt   = '0;
                end
            end
            SCAN_SHOW: begin
                w_digit_sel = 3'b001 << r_pos;
                if (r_cnt == SHOW_LAST) begin
                    w_advance   = 1'b1;
                    w_pos_nxt   = w_pos_inc;
                    w_cnt_nxt   = '0;
                    w_state_nxt = (BLANK_GAP == 0) ? SCAN_SHOW : SCAN_GAP;
                end
            end
            default: begin
                w_state_nxt = SCAN_GAP;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_digit_sel = w_digit_sel;
    assign o_advance   = w_advance;
    assign o_next_pos  = w_pos_nxt;

endmodule

// File: rtl/day_glyph_scanner.sv
// Day-of-week register with set/tick arbitration, feeding a time-multiplexed
// 3-glyph abbreviation to a single-glyph 7-segment decoder.
module day_glyph_scanner
    import day_glyph_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 1000,
    parameter int unsigned BLANK_GAP = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       day_tick,
    input  logic       set_valid,
    input  logic [2:0] set_day,
    output logic [2:0] day,
    output logic [4:0] glyph_code,
    output logic [2:0] digit_sel,
    output logic       set_err
);

    day_t       r_day;
    glyph_t     r_glyph;
    logic       r_set_err;
    logic       w_set_ok;
    logic       w_set_bad;
    logic       w_advance;
    logic [1:0] w_next_pos;
    logic [2:0] w_digit_sel;

    assign w_set_ok  = set_valid && (set_day != DAY_INVALID);
    assign w_set_bad = set_valid && (set_day == DAY_INVALID);

    scan_timer #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_GAP (BLANK_GAP)
    ) u_scan_timer (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .o_digit_sel (w_digit_sel),
        .o_advance   (w_advance),
        .o_next_pos  (w_next_pos)
    );

    // A rejected set leaves the tick path open; a valid set swallows the tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_day     <= '0;
            r_glyph   <= GLYPH_TABLE[0][0];
            r_set_err <= 1'b0;
        end else begin
            r_set_err <= w_set_bad;
            if (w_set_ok) begin
                r_day <= set_day;
            end else if (day_tick) begin
                r_day <= (r_day == DAY_MAX) ? '0 : r_day + 3'd1;
            end
            if (w_advance) begin
                r_glyph <= glyph_lookup(r_day, w_next_pos);
            end
        end
    end

    assign day        = r_day;
    assign glyph_code = r_glyph;
    assign digit_sel  = w_digit_sel;
    assign set_err    = r_set_err;

endmodule
